not_gate_32bit: RTL and testbench
=================================

// Module: not_gate_32bit
// PURPOSE
//  32-bit bitwise inverter for the ALU logic unit: Y = ~A, purely combinational, zero latency.
//  Also provides a registered copy with a valid strobe for pipelined ALU result muxing.
//  Optional status flags on the registered result feed the ALU flag logic.
// PARAMETERS
//  WIDTH    32   operand width; all behaviour below is specified and verified at 32 only
//  CNT_W    6    popcount width, $clog2(WIDTH)+1
// PORTS
//  clk       in   1      rising-edge clock, registered path only
//  rst_n     in   1      synchronous active-low reset
//  Y         out  32     combinational result, ~A
//  A         in   32     operand
//  in_valid  in   1      A qualifies for capture this cycle
//  Y_q       out  32     registered ~A
//  out_valid out  1      Y_q holds a fresh result
//  zero_q    out  1      Y_q == 0 (flag option)
//  ones_q    out  1      Y_q == all ones (flag option)
//  pop_q     out  CNT_W  number of 1 bits in Y_q (flag option)
// BEHAVIOUR
//  - Declaration order: Y, A, clk, rst_n, in_valid, Y_q, out_valid, zero_q, ones_q, pop_q.
//    A positional (Y, A) instantiation with the remaining ports unconnected is legal.
//  - Y = ~A, bit for bit. No clock and no reset dependence.
//  - Y settles within the same delta cycle as A and ignores clk, rst_n and in_valid.
//  - Y with A undriven or X is don't-care.
//  - Registered path, 1-cycle latency, at each posedge clk:
//    - rst_n==0: Y_q=0, out_valid=0, zero_q=0, ones_q=0, pop_q=0.
//      Reset wins over a simultaneous in_valid.
//    - else if in_valid: Y_q<=~A, out_valid<=1.
//    - else: Y_q holds, out_valid<=0.
//  - No backpressure. Back-to-back in_valid captures every cycle.
//  - Reset mid-stream discards the pending result. The first capture after release appears one
//    cycle after the first in_valid sampled with rst_n==1.
//  - Flags are registered with Y_q, in the same cycle, and computed from ~A, not from the old Y_q.
//  - pop_q range is 0..32. ~0 gives 32, which needs CNT_W=6.
//  - Without rst_n asserted, all registers are X at time zero.
// CONFIGURATION
//  - NOT_GATE_32BIT_FLAGS_EN defined:
//    - zero_q, ones_q and pop_q are implemented as registered popcount/compare of ~A.
//    - zero_q is 1 iff pop==0. ones_q is 1 iff pop==32.
//  - NOT_GATE_32BIT_FLAGS_EN undefined:
//    - zero_q, ones_q and pop_q are tied to constant 0.
//    - No flag logic is synthesized.
//    - Y, Y_q and out_valid are unaffected.
// TESTING
//  - A=0x00000000 -> Y=0xFFFFFFFF; with in_valid, next edge Y_q=0xFFFFFFFF, ones_q=1, pop_q=32.
//  - A=0xFFFFFFFF -> Y=0x00000000; next edge Y_q=0, zero_q=1, pop_q=0.
//  - A=0xA5A5A5A5 -> Y=0x5A5A5A5A; next edge pop_q=16, zero_q=0, ones_q=0.
//  - A=0x5A5A5A5A -> Y=0xA5A5A5A5 within 1 ns with clk stopped, confirming the path is
//    combinational.
//  - Reset: rst_n=0 together with in_valid=1 and A=0x12345678 -> next edge Y_q=0, out_valid=0.
//    Release, then in_valid -> Y_q=0xEDCBA987.
//  - Flags macro undefined: repeat the first scenario -> Y_q=0xFFFFFFFF, zero_q=ones_q=0,
//    pop_q=0.

Source files
------------

// File: rtl/not_gate_32bit.sv
`default_nettype none
// ============================================================================
// Module   : not_gate_32bit
// Purpose  : 32-bit bitwise inverter for the ALU logic unit. Provides a
//            combinational result Y = ~A, plus a registered copy Y_q with a
//            valid strobe for pipelined result muxing.
// Options  : NOT_GATE_32BIT_FLAGS_EN - when defined, registered zero/ones/
//            popcount flags of ~A are produced alongside Y_q; otherwise the
//            flag outputs are tied to 0 and no flag logic exists.
// Revision : 1.0 - initial release
// ============================================================================
module not_gate_32bit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    output logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] A,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Y_q,
    output logic             out_valid,
    output logic             zero_q,
    output logic             ones_q,
    output logic [CNT_W-1:0] pop_q
);

    // Inverted operand, shared by the combinational output and the capture path.
    logic [WIDTH-1:0] inv_a;

    assign inv_a = ~A;
    assign Y     = inv_a;

    // Result register: capture ~A on in_valid, hold otherwise; valid is a one-cycle strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Y_q       <= '0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            Y_q       <= inv_a;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef NOT_GATE_32BIT_FLAGS_EN
    // Flags are derived from the value being captured, not from the old Y_q,
    // so they line up with Y_q in the same cycle.
    logic [CNT_W-1:0] pop_next;

    // Population count of the inverted operand.
    always_comb begin
        pop_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_next = pop_next + CNT_W'(inv_a[i]);
        end
    end

    // Flag registers track Y_q: loaded on capture, held otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            ones_q <= 1'b0;
            pop_q  <= '0;
        end else if (in_valid) begin
            zero_q <= (pop_next == '0);
            ones_q <= (pop_next == CNT_W'(WIDTH));
            pop_q  <= pop_next;
        end
    end
`else
    assign zero_q = 1'b0;
    assign ones_q = 1'b0;
    assign pop_q  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_not_gate_32bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_not_gate_32bit
// Purpose  : Self-checking bench for not_gate_32bit: table of directed
//            vectors plus hand-written reset, hold and stopped-clock sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_not_gate_32bit;

    logic [31:0] A;
    logic [31:0] Y;
    logic        clk;
    logic        clk_run;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] Y_q;
    logic        out_valid;
    logic        zero_q;
    logic        ones_q;
    logic [5:0]  pop_q;

    int checks;
    int errors;

    typedef struct {
        logic [31:0] a;
        logic [31:0] y;
        logic [5:0]  pop;
        logic        zero;
        logic        ones;
    } vec_t;

    vec_t vecs[7];

    not_gate_32bit #(.WIDTH(32), .CNT_W(6)) dut (
        .Y         (Y),
        .A         (A),
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .Y_q       (Y_q),
        .out_valid (out_valid),
        .zero_q    (zero_q),
        .ones_q    (ones_q),
        .pop_q     (pop_q)
    );

    // Free-running clock that can be frozen low to probe the combinational path.
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected flag values depend on whether the flag option is built in.
    task automatic chk_flags(input string name, input logic [5:0] pop, input logic z, input logic o);
`ifdef NOT_GATE_32BIT_FLAGS_EN
        chk({name, ".pop_q"},  {26'd0, pop_q}, {26'd0, pop});
        chk({name, ".zero_q"}, {31'd0, zero_q}, {31'd0, z});
        chk({name, ".ones_q"}, {31'd0, ones_q}, {31'd0, o});
`else
        chk({name, ".pop_q"},  {26'd0, pop_q}, 32'd0);
        chk({name, ".zero_q"}, {31'd0, zero_q}, 32'd0);
        chk({name, ".ones_q"}, {31'd0, ones_q}, 32'd0);
`endif
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        clk      = 1'b0;
        clk_run  = 1'b1;

        vecs[0] = '{32'h0000_0000, 32'hFFFF_FFFF, 6'd32, 1'b0, 1'b1};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 6'd0,  1'b1, 1'b0};
        vecs[2] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 6'd16, 1'b0, 1'b0};
        vecs[3] = '{32'h5A5A_5A5A, 32'hA5A5_A5A5, 6'd16, 1'b0, 1'b0};
        vecs[4] = '{32'h1234_5678, 32'hEDCB_A987, 6'd19, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0001, 32'hFFFF_FFFE, 6'd31, 1'b0, 1'b0};
        vecs[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 6'd31, 1'b0, 1'b0};

        // Reset wins over a simultaneous in_valid.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        A        = 32'h1234_5678;
        @(posedge clk); #1;
        chk("rst.Y_q", Y_q, 32'h0);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk_flags("rst", 6'd0, 1'b0, 1'b0);
        chk("rst.Y_comb", Y, 32'hEDCB_A987);

        // First capture after release.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel.Y_q", Y_q, 32'hEDCB_A987);
        chk("rel.out_valid", {31'd0, out_valid}, 32'd1);
        chk_flags("rel", 6'd19, 1'b0, 1'b0);

        // Back-to-back captures from the vector table.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            A        = vecs[i].a;
            in_valid = 1'b1;
            #1;
            chk($sformatf("v%0d.Y", i), Y, vecs[i].y);
            @(posedge clk); #1;
            chk($sformatf("v%0d.Y_q", i), Y_q, vecs[i].y);
            chk($sformatf("v%0d.out_valid", i), {31'd0, out_valid}, 32'd1);
            chk_flags($sformatf("v%0d", i), vecs[i].pop, vecs[i].zero, vecs[i].ones);
        end

        // Without in_valid: Y_q and flags hold, out_valid drops, Y still follows A.
        @(negedge clk);
        in_valid = 1'b0;
        A        = 32'h0F0F_0000;
        #1;
        chk("hold.Y", Y, 32'hF0F0_FFFF);
        @(posedge clk); #1;
        chk("hold.Y_q", Y_q, 32'h7FFF_FFFF);
        chk("hold.out_valid", {31'd0, out_valid}, 32'd0);
        chk_flags("hold", 6'd31, 1'b0, 1'b0);

        // Stop the clock: Y must follow A combinationally, Y_q must not move.
        @(negedge clk);
        clk_run = 1'b0;
        A       = 32'h5A5A_5A5A;
        #1;
        chk("stop.Y", Y, 32'hA5A5_A5A5);
        in_valid = 1'b1;
        rst_n    = 1'b0;
        A        = 32'hFFFF_0000;
        #20;
        chk("stop.Y_rst", Y, 32'h0000_FFFF);
        chk("stop.Y_q", Y_q, 32'h7FFF_FFFF);
        rst_n   = 1'b1;
        clk_run = 1'b1;

        // Capture, then reset mid-stream discards the pending result.
        @(posedge clk); #1;
        chk("cap.Y_q", Y_q, 32'h0000_FFFF);
        chk_flags("cap", 6'd16, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        A     = 32'h0000_0000;
        @(posedge clk); #1;
        chk("mid.Y_q", Y_q, 32'h0);
        chk("mid.out_valid", {31'd0, out_valid}, 32'd0);
        chk_flags("mid", 6'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post.Y_q", Y_q, 32'hFFFF_FFFF);
        chk("post.out_valid", {31'd0, out_valid}, 32'd1);
        chk_flags("post", 6'd32, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
